// File: rtl/font_glyph_renderer_pkg.sv
// Shared constants and types for the 5x8 text glyph renderer.
// Font ROM layout: 5 column bytes per character, bit 0 = top row.
// State encoding used by the renderer FSM.
package font_glyph_renderer_pkg;

  localparam int FONT_BYTES_PER_CHAR = 5;
  localparam int GLYPH_ROWS          = 8;
  localparam int FONT_ADDR_W         = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Base byte address of a character: code*5 built as (code<<2)+code.
  function automatic logic [FONT_ADDR_W-1:0] font_base(input logic [7:0] code);
    logic [FONT_ADDR_W-1:0] c;
    c = FONT_ADDR_W'(code);
    return (c << 2) + c;
  endfunction

endpackage

// File: rtl/font_glyph_renderer.sv
// Purpose: fetch the 5 column bytes of a glyph and stream the cell as RGB565 pixels.
// Latency: first pixel valid 7 cycles after accept; 8*CW pixels then ready again.
// Backpressure: registered output holds data/last while pix_valid && !pix_ready.
module font_glyph_renderer
  import font_glyph_renderer_pkg::*;
#(
  parameter int PIX_W   = 16,
  parameter int SPACING = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   char_valid,
  output logic                   char_ready,
  input  logic [7:0]             char_code,
  input  logic [PIX_W-1:0]       fg,
  input  logic [PIX_W-1:0]       bg,
  output logic [FONT_ADDR_W-1:0] font_addr,
  input  logic [7:0]             font_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [PIX_W-1:0]       pix_data,
  output logic                   pix_last
);

  localparam int         CW        = FONT_BYTES_PER_CHAR + SPACING;
  localparam logic [2:0] LAST_COL  = 3'(CW - 1);
  localparam logic [2:0] LAST_ROW  = 3'(GLYPH_ROWS - 1);
  localparam logic [2:0] NUM_COLS  = 3'(FONT_BYTES_PER_CHAR);

  state_t           state;
  logic [2:0]       cnt;
  logic [2:0]       row;
  logic [2:0]       col;
  logic [7:0]       colbuf [FONT_BYTES_PER_CHAR];
  logic [PIX_W-1:0] fg_q;
  logic [PIX_W-1:0] bg_q;

  logic [2:0]       sel_row;
  logic [2:0]       sel_col;
  logic [2:0]       buf_idx;
  logic [PIX_W-1:0] nxt_pix;

  // Request side: busy from accept until the final pixel handshakes; low while in reset.
  assign char_ready = !rst && (state == IDLE);

  // Position and colour of the pixel to load next: (0,0) when leaving FETCH, else successor of (row,col).
  always_comb begin
    sel_row = row;
    sel_col = col;
    if (state == FETCH) begin
      sel_row = '0;
      sel_col = '0;
    end else if (col == LAST_COL) begin
      sel_col = '0;
      sel_row = row + 3'd1;
    end else begin
      sel_col = col + 3'd1;
    end
    buf_idx = (sel_col < NUM_COLS) ? sel_col : '0;
    nxt_pix = ((sel_col < NUM_COLS) && colbuf[buf_idx][sel_row]) ? fg_q : bg_q;
  end

  // Main FSM: address generation, column capture and the registered pixel output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      row       <= '0;
      col       <= '0;
      fg_q      <= '0;
      bg_q      <= '0;
      font_addr <= '0;
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
      pix_data  <= '0;
      for (int i = 0; i < FONT_BYTES_PER_CHAR; i++) colbuf[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (char_valid) begin
            fg_q      <= fg;
            bg_q      <= bg;
            font_addr <= font_base(char_code);
            cnt       <= '0;
            state     <= FETCH;
          end
        end
        FETCH: begin
          // Read data lags the address by one cycle, so byte k lands while cnt == k+1.
          if (cnt != 3'd0) colbuf[cnt - 3'd1] <= font_data;
          font_addr <= (cnt < 3'd4) ? font_addr + 1'b1 : '0;
          if (cnt == 3'd5) begin
            row       <= '0;
            col       <= '0;
            pix_valid <= 1'b1;
            pix_data  <= nxt_pix;
            pix_last  <= 1'b0;
            state     <= STREAM;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        STREAM: begin
          if (pix_ready) begin
            if (pix_last) begin
              pix_valid <= 1'b0;
              pix_last  <= 1'b0;
              state     <= IDLE;
            end else begin
              row      <= sel_row;
              col      <= sel_col;
              pix_data <= nxt_pix;
              pix_last <= (sel_row == LAST_ROW) && (sel_col == LAST_COL);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_font_glyph_renderer.sv
// Self-checking bench for font_glyph_renderer with a registered font ROM model.
// Expected pixels are queued at each accept and compared on every handshake.
// Covers reset, 'A', blank, top address, random backpressure, back-to-back, mid-cell reset.
module tb_font_glyph_renderer;

  localparam int NPIX = 48;

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        char_valid;
  logic        char_ready;
  logic [7:0]  char_code;
  logic [15:0] fg;
  logic [15:0] bg;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data;
  logic        pix_last;

  font_glyph_renderer #(.PIX_W(16), .SPACING(1)) dut (
    .clk(clk), .rst(rst),
    .char_valid(char_valid), .char_ready(char_ready), .char_code(char_code),
    .fg(fg), .bg(bg),
    .font_addr(font_addr), .font_data(font_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_last(pix_last)
  );

  always #5 clk = ~clk;

  // Registered font ROM model
  logic [7:0] font_mem [0:1279];
  always @(posedge clk) font_data <= (font_addr < 11'd1280) ? font_mem[font_addr] : 8'h00;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pix_t        exp_q[$];
  int          acc_cyc[$];
  int          last_cyc[$];
  int          accepts = 0;
  int          fetch_k = 0;
  int          fbase = 0;
  int          cell_pix = 0;
  logic [15:0] got [0:NPIX-1];
  logic        held = 1'b0;
  pix_t        held_v;
  bit          full_rate = 1'b1;
  bit          rand_ready = 1'b0;

  // Downstream ready driver
  always @(posedge clk) begin
    #1 pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    pix_t e;
    if (rst) begin
      fetch_k = 0;
      held    = 1'b0;
      check("rst_char_ready", char_ready, 0);
    end else begin
      if (held) begin
        check("hold_valid", pix_valid, 1);
        check("hold_data", pix_data, held_v.data);
        check("hold_last", pix_last, held_v.last);
      end
      if (fetch_k >= 1 && fetch_k <= 5) check("font_addr", font_addr, fbase + fetch_k - 1);
      else if (fetch_k == 6) check("valid_at_T6", pix_valid, 0);
      else if (fetch_k == 7) check("first_pix_T7", pix_valid, 1);
      if (fetch_k > 0) fetch_k = (fetch_k == 7) ? 0 : fetch_k + 1;
      if (pix_valid) check("char_ready_busy", char_ready, 0);
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) check("unexpected_pix", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("pix_data", pix_data, e.data);
          check("pix_last", pix_last, e.last);
        end
        if (cell_pix < NPIX) got[cell_pix] = pix_data;
        cell_pix++;
        if (pix_last) begin
          last_cyc.push_back(cyc);
          if (full_rate) check("last_pix_cycle", cyc - acc_cyc[acc_cyc.size()-1], 54);
        end
      end
      held     = pix_valid && !pix_ready;
      held_v   = '{last: pix_last, data: pix_data};
      if (char_valid && char_ready) begin
        accepts++;
        acc_cyc.push_back(cyc);
        fbase    = int'(char_code) * 5;
        fetch_k  = 1;
        cell_pix = 0;
        for (int r = 0; r < 8; r++) begin
          for (int c = 0; c < 6; c++) begin
            logic b;
            b = (c < 5) ? font_mem[fbase + c][r] : 1'b0;
            exp_q.push_back('{last: (r == 7 && c == 5), data: (b ? fg : bg)});
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] code, input logic [15:0] f, input logic [15:0] b);
    int n;
    @(posedge clk); #1;
    char_code  = code;
    fg         = f;
    bg         = b;
    char_valid = 1'b1;
    n = accepts;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (accepts > n) break;
    end
    if (accepts == n) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    char_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && char_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  task automatic check_a_cell();
    check("A_r0c0", got[0], 16'h0000);
    check("A_r0c2", got[2], 16'hFFFF);
    check("A_r0c5", got[5], 16'h0000);
    check("A_r6c0", got[36], 16'hFFFF);
    check("A_r6c1", got[37], 16'h0000);
    check("A_r6c4", got[40], 16'hFFFF);
    for (int i = 42; i < 48; i++) check("A_r7", got[i], 16'h0000);
  endtask

  initial begin
    int na;
    int nl;
    char_valid = 1'b0;
    char_code  = 8'h00;
    fg         = 16'h0000;
    bg         = 16'h0000;
    pix_ready  = 1'b1;
    for (int i = 0; i < 1280; i++) font_mem[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) font_mem[i] = 8'h00;
    font_mem[16'h145] = 8'h7C;
    font_mem[16'h146] = 8'h12;
    font_mem[16'h147] = 8'h11;
    font_mem[16'h148] = 8'h12;
    font_mem[16'h149] = 8'h7C;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_pix_valid", pix_valid, 0);
    check("reset_pix_last", pix_last, 0);
    check("reset_pix_data", pix_data, 0);
    check("reset_font_addr", font_addr, 0);
    check("reset_char_ready", char_ready, 1);

    // 'A' at full rate
    send(8'h41, 16'hFFFF, 16'h0000);
    wait_done();
    check_a_cell();

    // Blank glyph at code 0
    send(8'h00, 16'hFFFF, 16'h001F);
    wait_done();
    for (int i = 0; i < NPIX; i++) check("blank_pix", got[i], 16'h001F);

    // Top address boundary
    send(8'hFF, 16'hF800, 16'h07E0);
    wait_done();

    // Random backpressure on 'A'
    full_rate  = 1'b0;
    rand_ready = 1'b1;
    send(8'h41, 16'hFFFF, 16'h0000);
    wait_done();
    check_a_cell();
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    full_rate  = 1'b1;

    // Back-to-back with char_valid held high
    na = acc_cyc.size();
    nl = last_cyc.size();
    @(posedge clk); #1;
    char_code  = 8'h41;
    fg         = 16'h1234;
    bg         = 16'hABCD;
    char_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (accepts >= na + 2) break;
    end
    @(posedge clk); #1;
    char_valid = 1'b0;
    wait_done();
    if (acc_cyc.size() >= na + 2 && last_cyc.size() >= nl + 1) begin
      check("b2b_period", acc_cyc[na+1] - acc_cyc[na], 55);
      check("b2b_after_last", acc_cyc[na+1] - last_cyc[nl], 1);
    end else begin
      check("b2b_accepts", acc_cyc.size(), na + 2);
    end

    // Reset in the middle of a cell
    send(8'h41, 16'hFFFF, 16'h0000);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cell_pix >= 20) break;
    end
    check("reached_pix20", (cell_pix >= 20) ? 1 : 0, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_pix_valid", pix_valid, 0);
    check("midrst_pix_last", pix_last, 0);
    check("midrst_char_ready", char_ready, 1);
    check("midrst_font_addr", font_addr, 0);
    send(8'h41, 16'hFFFF, 16'h0000);
    wait_done();
    check_a_cell();
    check("post_rst_pix_count", cell_pix, NPIX);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
